// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the fetch PC unit: FSM states, default sizing
// constants and the redirect-target alignment check.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  localparam int unsigned DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned DEF_INC          = 4;
  localparam int unsigned DEF_ALIGN_BITS   = 2;
  localparam int unsigned DEF_CNT_W        = 32;

  // True when any of the low align_bits bits of addr is set. Callers
  // zero-extend their address to 64 bits so one function serves any XLEN.
  function automatic logic is_misaligned(input logic [63:0] addr,
                                         input int unsigned align_bits);
    logic [63:0] mask;
    mask = (64'd1 << align_bits) - 64'd1;
    return |(addr & mask);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_seq_adder.sv
// XLEN-bit constant-increment adder. One instance feeds both the
// link-register output and the sequential PC update. Wraps modulo 2^XLEN.
module pc_seq_adder
  import rv_fetch_pkg::*;
#(
  parameter int unsigned XLEN = DEF_XLEN,
  parameter int unsigned INC  = DEF_INC
) (
  input  logic [XLEN-1:0] i_a,
  output logic [XLEN-1:0] o_sum
);

  assign o_sum = i_a + XLEN'(INC);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request unit.
//
// state | meaning
// BOOT  | one idle cycle after reset release, no request issued
// RUN   | issuing requests at pc; redirects, stalls and accepts move pc
// TRAP  | misaligned redirect seen; waiting for trap_ack to resume at vector
module pc_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int unsigned     INC          = DEF_INC,
  parameter int unsigned     ALIGN_BITS   = DEF_ALIGN_BITS,
  parameter int unsigned     CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  fetch_pc,
  output logic [XLEN-1:0]  pc_next_seq,
  output logic             trap_valid,
  output logic [XLEN-1:0]  trap_badaddr,
  input  logic             trap_ack,
  input  logic [XLEN-1:0]  trap_vector,
  output logic [CNT_W-1:0] fetch_count
);

  // Clears the low ALIGN_BITS bits of an address.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

  fetch_state_t     r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_trap_badaddr;
  logic [CNT_W-1:0] r_fetch_count;

  logic [XLEN-1:0]  w_pc_inc;
  logic [63:0]      w_target_ext;
  logic             w_target_misaligned;
  logic             w_fetch_valid;
  logic             w_fetch_fire;

  pc_seq_adder #(
    .XLEN (XLEN),
    .INC  (INC)
  ) u_pc_seq_adder (
    .i_a   (r_pc),
    .o_sum (w_pc_inc)
  );

  assign w_target_ext        = 64'(redirect_target);
  assign w_target_misaligned = is_misaligned(w_target_ext, ALIGN_BITS);

  // A request is only offered in RUN; stall withdraws it combinationally.
  assign w_fetch_valid = (r_state == RUN) && !stall;
  assign w_fetch_fire  = w_fetch_valid && fetch_ready;

  assign fetch_valid  = w_fetch_valid;
  assign fetch_pc     = r_pc;
  assign pc_next_seq  = w_pc_inc;
  assign trap_valid   = (r_state == TRAP);
  assign trap_badaddr = r_trap_badaddr;
  assign fetch_count  = r_fetch_count;

  // Sequencing FSM with PC, trap address and accepted-fetch counter.
  // Redirects win over the handshake, so an accept coinciding with a
  // redirect is dropped and not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= BOOT;
      r_pc           <= RESET_VECTOR;
      r_trap_badaddr <= '0;
      r_fetch_count  <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= RUN;
        end
        RUN: begin
          if (redirect_valid && w_target_misaligned) begin
            r_state        <= TRAP;
            r_trap_badaddr <= redirect_target;
          end else if (redirect_valid) begin
            r_pc <= redirect_target;
          end else if (w_fetch_fire) begin
            r_pc          <= w_pc_inc;
            r_fetch_count <= r_fetch_count + CNT_W'(1);
          end
        end
        TRAP: begin
          if (trap_ack) begin
            r_pc    <= trap_vector & ALIGN_MASK;
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= BOOT;
        end
      endcase
    end
  end

  // A trap and a fetch request are mutually exclusive.
  property p_trap_fetch_exclusive;
    @(posedge clk) disable iff (reset) !(fetch_valid && trap_valid);
  endproperty
  a_trap_fetch_exclusive: assert property (p_trap_fetch_exclusive);

  // The PC never holds a misaligned value.
  property p_pc_aligned;
    @(posedge clk) disable iff (reset) ((r_pc & ~ALIGN_MASK) == '0);
  endproperty
  a_pc_aligned: assert property (p_pc_aligned);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        fetch_ready = 1'b0;
  logic        trap_ack = 1'b0;
  logic [31:0] trap_vector = 32'h0;

  logic        fv_a, tv_a, fv_b, tv_b;
  logic [31:0] fpc_a, nseq_a, bad_a, cnt_a;
  logic [31:0] fpc_b, nseq_b, bad_b, cnt_b;

  int n_total = 0;
  int n_bad   = 0;

  // reference model of instance A (defaults: INC=4, 2 align bits, vector 0)
  int          m_mode;  // 0 boot, 1 run, 2 trap
  logic [31:0] m_pc, m_bad, m_cnt;

  always #5 clk = ~clk;

  pc_fetch_unit dut_a (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_valid(fv_a), .fetch_ready(fetch_ready), .fetch_pc(fpc_a),
    .pc_next_seq(nseq_a), .trap_valid(tv_a), .trap_badaddr(bad_a),
    .trap_ack(trap_ack), .trap_vector(trap_vector), .fetch_count(cnt_a)
  );

  pc_fetch_unit #(
    .RESET_VECTOR(32'h0000_1000), .INC(2), .ALIGN_BITS(1)
  ) dut_b (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_valid(fv_b), .fetch_ready(fetch_ready), .fetch_pc(fpc_b),
    .pc_next_seq(nseq_b), .trap_valid(tv_b), .trap_badaddr(bad_b),
    .trap_ack(trap_ack), .trap_vector(trap_vector), .fetch_count(cnt_b)
  );

  // advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_pc = 32'h0; m_cnt = 32'h0; m_bad = 32'h0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          if (redirect_valid && (redirect_target % 4 != 0)) begin
            m_mode = 2; m_bad = redirect_target;
          end else if (redirect_valid) begin
            m_pc = redirect_target;
          end else if (!stall && fetch_ready) begin
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
          end
        end
        default: begin
          if (trap_ack) begin
            m_pc = trap_vector - (trap_vector % 4); m_mode = 1;
          end
        end
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; trap_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_ready = 1'b1; stall = 1'b0;
    tick(); tick();
    n_total++; if (fv_a !== 1'b0) begin n_bad++; $display("FAIL rst_fv got=%b want=0", fv_a); end
    n_total++; if (tv_a !== 1'b0) begin n_bad++; $display("FAIL rst_tv got=%b want=0", tv_a); end
    n_total++; if (fpc_a !== 32'h0) begin n_bad++; $display("FAIL rst_pc got=%h want=0", fpc_a); end
    n_total++; if (cnt_a !== 32'h0) begin n_bad++; $display("FAIL rst_cnt got=%0d want=0", cnt_a); end
    n_total++; if (bad_a !== 32'h0) begin n_bad++; $display("FAIL rst_badaddr got=%h want=0", bad_a); end
    n_total++; if (fpc_b !== 32'h1000) begin n_bad++; $display("FAIL rst_pc_b got=%h want=1000", fpc_b); end
    reset = 1'b0;
    #1;
    n_total++; if (fv_a !== 1'b0) begin n_bad++; $display("FAIL boot_fv got=%b want=0", fv_a); end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_total++; if (fv_a !== 1'b1) begin n_bad++; $display("FAIL seq_fv%0d got=%b want=1", i, fv_a); end
      n_total++; if (fpc_a !== 32'(i * 4)) begin n_bad++; $display("FAIL seq_pc%0d got=%h want=%h", i, fpc_a, 32'(i * 4)); end
      tick();
    end
    n_total++; if (cnt_a !== 32'd4) begin n_bad++; $display("FAIL seq_cnt got=%0d want=4", cnt_a); end
  endtask

  task automatic test_backpressure();
    logic [31:0] c0;
    redirect_valid = 1'b1; redirect_target = 32'h8;
    tick();
    redirect_valid = 1'b0; fetch_ready = 1'b0;
    #1;
    c0 = cnt_a;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (fpc_a !== 32'h8) begin n_bad++; $display("FAIL bp_pc%0d got=%h want=8", i, fpc_a); end
      n_total++; if (fv_a !== 1'b1) begin n_bad++; $display("FAIL bp_fv%0d got=%b want=1", i, fv_a); end
      n_total++; if (cnt_a !== c0) begin n_bad++; $display("FAIL bp_cnt%0d got=%0d want=%0d", i, cnt_a, c0); end
      tick();
    end
    fetch_ready = 1'b1;
    #1;
    n_total++; if (fpc_a !== 32'h8) begin n_bad++; $display("FAIL bp_hold got=%h want=8", fpc_a); end
    tick();
    n_total++; if (fpc_a !== 32'hC) begin n_bad++; $display("FAIL bp_release got=%h want=c", fpc_a); end
    n_total++; if (cnt_a !== c0 + 32'd1) begin n_bad++; $display("FAIL bp_cnt_inc got=%0d want=%0d", cnt_a, c0 + 32'd1); end
  endtask

  task automatic test_redirect_stall();
    logic [31:0] c0;
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (fpc_a !== 32'h100) begin n_bad++; $display("FAIL rs_pc got=%h want=100", fpc_a); end
    n_total++; if (fv_a !== 1'b0) begin n_bad++; $display("FAIL rs_fv_stall got=%b want=0", fv_a); end
    stall = 1'b0;
    #1;
    n_total++; if (fv_a !== 1'b1) begin n_bad++; $display("FAIL rs_fv_unstall got=%b want=1", fv_a); end
    redirect_valid = 1'b1; redirect_target = 32'h10;
    tick();
    n_total++; if (fpc_a !== 32'h10) begin n_bad++; $display("FAIL ra_pc10 got=%h want=10", fpc_a); end
    c0 = cnt_a;
    redirect_target = 32'h40; fetch_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (cnt_a !== c0) begin n_bad++; $display("FAIL ra_cnt got=%0d want=%0d", cnt_a, c0); end
    n_total++; if (fpc_a !== 32'h40) begin n_bad++; $display("FAIL ra_pc got=%h want=40", fpc_a); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_target = 32'h102;
    tick();
    redirect_target = 32'h200; stall = 1'b1;
    #1;
    n_total++; if (tv_a !== 1'b1) begin n_bad++; $display("FAIL mis_tv got=%b want=1", tv_a); end
    n_total++; if (bad_a !== 32'h102) begin n_bad++; $display("FAIL mis_badaddr got=%h want=102", bad_a); end
    n_total++; if (fv_a !== 1'b0) begin n_bad++; $display("FAIL mis_fv got=%b want=0", fv_a); end
    n_total++; if (fpc_a !== 32'h40) begin n_bad++; $display("FAIL mis_pc got=%h want=40", fpc_a); end
    tick();
    n_total++; if (tv_a !== 1'b1) begin n_bad++; $display("FAIL mis_ignore_tv got=%b want=1", tv_a); end
    n_total++; if (fpc_a !== 32'h40) begin n_bad++; $display("FAIL mis_ignore_pc got=%h want=40", fpc_a); end
    redirect_valid = 1'b0; stall = 1'b0; trap_ack = 1'b1; trap_vector = 32'h8000_0003;
    tick();
    trap_ack = 1'b0;
    #1;
    n_total++; if (fpc_a !== 32'h8000_0000) begin n_bad++; $display("FAIL ack_pc got=%h want=80000000", fpc_a); end
    n_total++; if (tv_a !== 1'b0) begin n_bad++; $display("FAIL ack_tv got=%b want=0", tv_a); end
    n_total++; if (fv_a !== 1'b1) begin n_bad++; $display("FAIL ack_fv got=%b want=1", fv_a); end
  endtask

  task automatic test_wrap();
    logic [31:0] c0;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (nseq_a !== 32'h0) begin n_bad++; $display("FAIL wrap_nseq0 got=%h want=0", nseq_a); end
    c0 = cnt_a;
    tick();
    n_total++; if (fpc_a !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got=%h want=0", fpc_a); end
    n_total++; if (nseq_a !== 32'h4) begin n_bad++; $display("FAIL wrap_nseq got=%h want=4", nseq_a); end
    n_total++; if (cnt_a !== c0 + 32'd1) begin n_bad++; $display("FAIL wrap_cnt got=%0d want=%0d", cnt_a, c0 + 32'd1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch_ready = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    redirect_valid = 1'b1; redirect_target = 32'h3;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (tv_a !== 1'b1) begin n_bad++; $display("FAIL mid_tv got=%b want=1", tv_a); end
    n_total++; if (cnt_a !== 32'd7) begin n_bad++; $display("FAIL mid_cnt7 got=%0d want=7", cnt_a); end
    reset = 1'b1; trap_ack = 1'b1; trap_vector = 32'h4000;
    tick();
    n_total++; if (fpc_a !== 32'h0) begin n_bad++; $display("FAIL mid_rst_pc got=%h want=0", fpc_a); end
    n_total++; if (tv_a !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tv got=%b want=0", tv_a); end
    n_total++; if (cnt_a !== 32'd0) begin n_bad++; $display("FAIL mid_rst_cnt got=%0d want=0", cnt_a); end
    n_total++; if (bad_a !== 32'h0) begin n_bad++; $display("FAIL mid_rst_badaddr got=%h want=0", bad_a); end
    reset = 1'b0; trap_ack = 1'b0;
    #1;
    n_total++; if (fv_a !== 1'b0) begin n_bad++; $display("FAIL mid_boot_fv got=%b want=0", fv_a); end
    tick(); tick();
    n_total++; if (fv_a !== 1'b1 || fpc_a !== 32'h4) begin n_bad++; $display("FAIL hs_pre got=%b/%h want=1/4", fv_a, fpc_a); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_total++; if (cnt_a !== 32'd0 || fpc_a !== 32'h0) begin n_bad++; $display("FAIL hs_rst got=%0d/%h want=0/0", cnt_a, fpc_a); end
  endtask

  task automatic test_params_b();
    do_reset();
    fetch_ready = 1'b1;
    n_total++; if (fv_b !== 1'b0 || fpc_b !== 32'h1000) begin n_bad++; $display("FAIL b_boot got=%b/%h want=0/1000", fv_b, fpc_b); end
    tick();
    n_total++; if (fpc_b !== 32'h1000) begin n_bad++; $display("FAIL b_pc0 got=%h want=1000", fpc_b); end
    n_total++; if (nseq_b !== 32'h1002) begin n_bad++; $display("FAIL b_nseq got=%h want=1002", nseq_b); end
    tick();
    n_total++; if (fpc_b !== 32'h1002) begin n_bad++; $display("FAIL b_pc1 got=%h want=1002", fpc_b); end
    tick();
    n_total++; if (fpc_b !== 32'h1004) begin n_bad++; $display("FAIL b_pc2 got=%h want=1004", fpc_b); end
    redirect_valid = 1'b1; redirect_target = 32'h1006;
    tick();
    n_total++; if (fpc_b !== 32'h1006 || tv_b !== 1'b0) begin n_bad++; $display("FAIL b_half_redirect got=%h/%b want=1006/0", fpc_b, tv_b); end
    redirect_target = 32'h1001;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (tv_b !== 1'b1 || bad_b !== 32'h1001) begin n_bad++; $display("FAIL b_trap got=%b/%h want=1/1001", tv_b, bad_b); end
    trap_ack = 1'b1; trap_vector = 32'h2003;
    tick();
    trap_ack = 1'b0;
    #1;
    n_total++; if (fpc_b !== 32'h2002) begin n_bad++; $display("FAIL b_ack_pc got=%h want=2002", fpc_b); end
  endtask

  task automatic test_random();
    logic        e_fv;
    logic [31:0] e_nseq;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset          = ($urandom_range(0, 63) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      fetch_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 5) == 0);
      trap_ack       = ($urandom_range(0, 2) == 0);
      trap_vector    = $urandom;
      case ($urandom_range(0, 3))
        0:       redirect_target = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        1:       redirect_target = 32'hFFFF_FFFC;
        default: redirect_target = $urandom & 32'hFFFF_FFFC;
      endcase
      #1;
      e_fv   = (m_mode == 1) && !stall;
      e_nseq = m_pc + 32'd4;
      n_total++; if (fv_a !== e_fv) begin n_bad++; $display("FAIL rnd_fv@%0d got=%b want=%b", i, fv_a, e_fv); end
      n_total++; if (fpc_a !== m_pc) begin n_bad++; $display("FAIL rnd_pc@%0d got=%h want=%h", i, fpc_a, m_pc); end
      n_total++; if (nseq_a !== e_nseq) begin n_bad++; $display("FAIL rnd_nseq@%0d got=%h want=%h", i, nseq_a, e_nseq); end
      n_total++; if (tv_a !== (m_mode == 2)) begin n_bad++; $display("FAIL rnd_tv@%0d got=%b want=%b", i, tv_a, (m_mode == 2)); end
      n_total++; if (bad_a !== m_bad) begin n_bad++; $display("FAIL rnd_badaddr@%0d got=%h want=%h", i, bad_a, m_bad); end
      n_total++; if (cnt_a !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt@%0d got=%0d want=%0d", i, cnt_a, m_cnt); end
      tick();
    end
    reset = 1'b0; redirect_valid = 1'b0; trap_ack = 1'b0; stall = 1'b0;
  endtask

  initial begin
    m_mode = 0; m_pc = 32'h0; m_bad = 32'h0; m_cnt = 32'h0;
    test_reset();
    test_backpressure();
    test_redirect_stall();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_params_b();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
